// File: rtl/axi4_wr_fifo_master.sv
// axi4_wr_fifo_master
//
// Drains the AW and W FIFOs of a buffered AXI4 write path onto an AXI4 master
// write port, and returns B responses into the B FIFO.
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   aw_rd_empty/aw_rd_en   AW FIFO status/pop (FWFT), head on fifo_aw*
//   w_rd_empty/w_rd_en     W FIFO status/pop (FWFT), head on fifo_w*
//   b_wr_full/b_wr_en      B FIFO status/push, data on fifo_bid/fifo_bresp
//   aw*, w*, b*            AXI4 master write channels
//   outstanding            AW handshakes not yet answered by a B push
//   wlast_err              sticky: FIFO wlast disagreed with generated wlast
module axi4_wr_fifo_master #(
    parameter int A       = 32,
    parameter int N       = 8,
    parameter int I       = 1,
    parameter int MAX_OUT = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         aw_rd_empty,
    output logic                         aw_rd_en,
    input  logic [I-1:0]                 fifo_awid,
    input  logic [A-1:0]                 fifo_awaddr,
    input  logic [7:0]                   fifo_awlen,
    input  logic [2:0]                   fifo_awsize,
    input  logic [1:0]                   fifo_awburst,
    input  logic                         w_rd_empty,
    output logic                         w_rd_en,
    input  logic [8*N-1:0]               fifo_wdata,
    input  logic [N-1:0]                 fifo_wstrb,
    input  logic                         fifo_wlast,
    input  logic                         b_wr_full,
    output logic                         b_wr_en,
    output logic [I-1:0]                 fifo_bid,
    output logic [1:0]                   fifo_bresp,
    output logic [I-1:0]                 awid,
    output logic [A-1:0]                 awaddr,
    output logic [7:0]                   awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [8*N-1:0]               wdata,
    output logic [N-1:0]                 wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [I-1:0]                 bid,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready,
    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic                         wlast_err
);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    typedef enum logic { AW_IDLE, AW_SEND } aw_state_t;
    typedef enum logic { W_IDLE, W_BURST } w_state_t;

    aw_state_t aw_state, aw_next;
    w_state_t  w_state, w_next;

    // Queue of awlen values for bursts whose AW has handshaken but whose
    // W data has not finished; pointers carry an extra wrap bit.
    logic [7:0]    lq_mem [MAX_OUT];
    logic [CW-1:0] lq_wr, lq_rd;
    logic          lq_empty, lq_full, lq_pop;

    logic [7:0] beat_cnt;
    logic       aw_hs, w_acc, b_dec;

    assign lq_empty = (lq_wr == lq_rd);
    assign lq_full  = (lq_wr[PW] != lq_rd[PW]) && (lq_wr[PW-1:0] == lq_rd[PW-1:0]);

    assign awvalid = (aw_state == AW_SEND);
    assign aw_hs   = awvalid && awready;

    assign wdata = fifo_wdata;
    assign wstrb = fifo_wstrb;

    assign bready     = aresetn && !b_wr_full;
    assign b_wr_en    = bvalid && bready;
    assign fifo_bid   = bid;
    assign fifo_bresp = bresp;
    // A B arriving with nothing outstanding is a protocol violation; ignore it
    assign b_dec      = b_wr_en && (outstanding != '0);

    always_comb begin
        aw_next  = aw_state;
        aw_rd_en = 1'b0;
        case (aw_state)
            AW_IDLE: begin
                if (!aw_rd_empty && (outstanding < MAX_CNT) && !lq_full) begin
                    aw_rd_en = 1'b1;
                    aw_next  = AW_SEND;
                end
            end
            AW_SEND: begin
                if (awready) aw_next = AW_IDLE;
            end
            default: aw_next = AW_IDLE;
        endcase
    end

    always_comb begin
        w_next  = w_state;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        w_acc   = 1'b0;
        w_rd_en = 1'b0;
        lq_pop  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (!lq_empty) w_next = W_BURST;
            end
            W_BURST: begin
                wvalid  = !w_rd_empty;
                wlast   = (beat_cnt == 8'd0);
                w_acc   = wvalid && wready;
                w_rd_en = w_acc;
                if (w_acc && wlast) begin
                    lq_pop = 1'b1;
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (aw_hs) lq_mem[lq_wr[PW-1:0]] <= awlen;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_state    <= AW_IDLE;
            w_state     <= W_IDLE;
            awid        <= '0;
            awaddr      <= '0;
            awlen       <= '0;
            awsize      <= '0;
            awburst     <= '0;
            lq_wr       <= '0;
            lq_rd       <= '0;
            beat_cnt    <= '0;
            outstanding <= '0;
            wlast_err   <= 1'b0;
        end else begin
            aw_state <= aw_next;
            w_state  <= w_next;
            if (aw_rd_en) begin
                awid    <= fifo_awid;
                awaddr  <= fifo_awaddr;
                awlen   <= fifo_awlen;
                awsize  <= fifo_awsize;
                awburst <= fifo_awburst;
            end
            if (aw_hs)  lq_wr <= lq_wr + CW'(1);
            if (lq_pop) lq_rd <= lq_rd + CW'(1);
            // beat_cnt counts remaining beats after the current one
            if (w_state == W_IDLE && !lq_empty)
                beat_cnt <= lq_mem[lq_rd[PW-1:0]];
            else if (w_acc)
                beat_cnt <= beat_cnt - 8'd1;
            if (w_acc && (fifo_wlast != wlast)) wlast_err <= 1'b1;
            if (aw_hs && !b_dec)
                outstanding <= outstanding + CW'(1);
            else if (!aw_hs && b_dec)
                outstanding <= outstanding - CW'(1);
        end
    end
endmodule

// File: tb/tb_axi4_wr_fifo_master.sv
// Directed bench for axi4_wr_fifo_master. The AW/W FIFOs are modelled as
// FWFT queues popped on the DUT's rd_en; AXI slave signals are driven by
// the directed steps below.
module tb_axi4_wr_fifo_master;
    localparam int A = 32, N = 8, I = 1, MAX_OUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aresetn, aw_rd_empty, aw_rd_en, w_rd_empty, w_rd_en, fifo_wlast;
    logic [I-1:0] fifo_awid, fifo_bid, awid, bid;
    logic [A-1:0] fifo_awaddr, awaddr;
    logic [7:0] fifo_awlen, awlen;
    logic [2:0] fifo_awsize, awsize;
    logic [1:0] fifo_awburst, awburst, fifo_bresp, bresp;
    logic [8*N-1:0] fifo_wdata, wdata;
    logic [N-1:0] fifo_wstrb, wstrb;
    logic b_wr_full, b_wr_en, awvalid, awready, wlast, wvalid, wready;
    logic bvalid, bready, wlast_err;
    logic [$clog2(MAX_OUT):0] outstanding;

    axi4_wr_fifo_master #(.A(A), .N(N), .I(I), .MAX_OUT(MAX_OUT)) dut (
        .aclk(clk), .aresetn(aresetn),
        .aw_rd_empty(aw_rd_empty), .aw_rd_en(aw_rd_en),
        .fifo_awid(fifo_awid), .fifo_awaddr(fifo_awaddr), .fifo_awlen(fifo_awlen),
        .fifo_awsize(fifo_awsize), .fifo_awburst(fifo_awburst),
        .w_rd_empty(w_rd_empty), .w_rd_en(w_rd_en),
        .fifo_wdata(fifo_wdata), .fifo_wstrb(fifo_wstrb), .fifo_wlast(fifo_wlast),
        .b_wr_full(b_wr_full), .b_wr_en(b_wr_en), .fifo_bid(fifo_bid), .fifo_bresp(fifo_bresp),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .outstanding(outstanding), .wlast_err(wlast_err)
    );

    typedef struct { logic [I-1:0] id; logic [A-1:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [8*N-1:0] data; logic last; } w_t;
    aw_t awq[$];
    w_t  wq[$];
    logic w_hold;

    logic [8*N-1:0] wl_data[$];
    logic           wl_last[$];
    logic [2:0]     bl[$];
    int aw_hs, wen_bad;
    int total, passed, fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_aw(input logic [I-1:0] id, input logic [A-1:0] addr, input logic [7:0] len);
        aw_t e;
        e.id = id; e.addr = addr; e.len = len;
        awq.push_back(e);
    endtask

    task automatic push_w(input logic [8*N-1:0] data, input logic last);
        w_t e;
        e.data = data; e.last = last;
        wq.push_back(e);
    endtask

    task automatic drive();
        aw_rd_empty = (awq.size() == 0);
        fifo_awid   = (awq.size() != 0) ? awq[0].id   : '0;
        fifo_awaddr = (awq.size() != 0) ? awq[0].addr : '0;
        fifo_awlen  = (awq.size() != 0) ? awq[0].len  : '0;
        w_rd_empty  = w_hold || (wq.size() == 0);
        fifo_wdata  = (wq.size() != 0) ? wq[0].data : '0;
        fifo_wlast  = (wq.size() != 0) ? wq[0].last : 1'b0;
        #1;
    endtask

    task automatic cycle();
        logic s_aw, s_w;
        drive();
        @(negedge clk);
        s_aw = aw_rd_en;
        s_w  = w_rd_en;
        if (awvalid && awready) aw_hs++;
        if (wvalid && wready) begin
            wl_data.push_back(wdata);
            wl_last.push_back(wlast);
        end
        if (w_rd_en !== (wvalid && wready)) wen_bad++;
        if (b_wr_en) bl.push_back({fifo_bid, fifo_bresp});
        @(posedge clk);
        #1;
        if (s_aw && awq.size() != 0) awq.delete(0);
        if (s_w && wq.size() != 0) wq.delete(0);
        drive();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_beats(input int n, input int max, input string tag);
        for (int i = 0; i < max && wl_data.size() < n; i++) cycle();
        chk(tag, 64'(wl_data.size() >= n), 64'd1);
    endtask

    task automatic send_b(input logic [I-1:0] id, input logic [1:0] resp);
        bvalid = 1'b1; bid = id; bresp = resp;
        cycle();
        bvalid = 1'b0;
    endtask

    task automatic clear_logs();
        aw_hs = 0;
        wl_data.delete();
        wl_last.delete();
        bl.delete();
    endtask

    initial begin
        logic [7:0] lastmask;
        total = 0; passed = 0; fails = 0; aw_hs = 0; wen_bad = 0;
        aresetn = 1'b0; w_hold = 1'b0;
        fifo_awsize = 3'd3; fifo_awburst = 2'b01; fifo_wstrb = '1;
        b_wr_full = 1'b0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0; bid = '0; bresp = '0;
        cycles(2);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_wlast_err", 64'(wlast_err), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_awaddr", 64'(awaddr), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        aresetn = 1'b1;
        cycle();

        // single write
        awready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 4; i++) push_w(64'h11 + 64'(i), i == 3);
        push_aw(1'b0, 32'h1000, 8'd3);
        drive();
        chk("t1_pop", 64'(aw_rd_en), 64'd1);
        chk("t1_awvalid_early", 64'(awvalid), 64'd0);
        cycle();
        chk("t1_awvalid", 64'(awvalid), 64'd1);
        chk("t1_awaddr", 64'(awaddr), 64'h1000);
        chk("t1_awlen", 64'(awlen), 64'd3);
        chk("t1_pop_once", 64'(aw_rd_en), 64'd0);
        cycle();
        chk("t1_out1", 64'(outstanding), 64'd1);
        wait_beats(4, 20, "t1_beats_timeout");
        lastmask = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_data%0d", i), wl_data[i], 64'h11 + 64'(i));
            lastmask[i] = wl_last[i];
        end
        chk("t1_wlast_pos", 64'(lastmask), 64'h08);
        cycle();
        send_b(1'b0, 2'b00);
        chk("t1_bpush", 64'(bl.size()), 64'd1);
        chk("t1_out0", 64'(outstanding), 64'd0);

        // outstanding limit
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            push_w(64'h20 + 64'(i), 1'b1);
            push_aw(1'b0, 32'h2000 + 32'(i) * 32'h100, 8'd0);
        end
        cycles(20);
        chk("t2_hs4", 64'(aw_hs), 64'd4);
        chk("t2_out4", 64'(outstanding), 64'd4);
        chk("t2_no_pop", 64'(aw_rd_en), 64'd0);
        chk("t2_aw_left", 64'(awq.size()), 64'd2);
        send_b(1'b1, 2'b00);
        cycles(4);
        chk("t2_hs5", 64'(aw_hs), 64'd5);
        chk("t2_out4b", 64'(outstanding), 64'd4);
        for (int i = 0; i < 5; i++) begin
            send_b(1'b1, 2'b00);
            cycles(3);
        end
        chk("t2_hs6", 64'(aw_hs), 64'd6);
        chk("t2_out_drain", 64'(outstanding), 64'd0);
        chk("t2_beats", 64'(wl_data.size()), 64'd6);

        // backpressure
        clear_logs();
        wen_bad = 0;
        push_aw(1'b0, 32'h3000, 8'd7);
        for (int i = 0; i < 8; i++) push_w(64'hA0 + 64'(i), i == 7);
        for (int k = 0; k < 60 && wl_data.size() < 8; k++) begin
            wready = (k % 2 == 0);
            w_hold = (k >= 6 && k < 9);
            cycle();
        end
        w_hold = 1'b0; wready = 1'b1;
        chk("t3_beats", 64'(wl_data.size()), 64'd8);
        lastmask = '0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_data%0d", i), wl_data[i], 64'hA0 + 64'(i));
            lastmask[i] = wl_last[i];
        end
        chk("t3_wlast_pos", 64'(lastmask), 64'h80);
        chk("t3_rd_en_rule", 64'(wen_bad), 64'd0);
        chk("t3_fifo_drained", 64'(wq.size()), 64'd0);
        cycle();
        send_b(1'b0, 2'b00);
        chk("t3_out0", 64'(outstanding), 64'd0);

        // B FIFO full
        clear_logs();
        push_aw(1'b1, 32'h4000, 8'd0);
        push_w(64'h55, 1'b1);
        cycles(6);
        chk("t4_out1", 64'(outstanding), 64'd1);
        b_wr_full = 1'b1; bvalid = 1'b1; bid = 1'b1; bresp = 2'b10;
        drive();
        chk("t4_bready_low", 64'(bready), 64'd0);
        chk("t4_no_push", 64'(b_wr_en), 64'd0);
        cycles(3);
        chk("t4_no_push_log", 64'(bl.size()), 64'd0);
        chk("t4_out_held", 64'(outstanding), 64'd1);
        b_wr_full = 1'b0;
        drive();
        chk("t4_bready", 64'(bready), 64'd1);
        chk("t4_push", 64'(b_wr_en), 64'd1);
        chk("t4_bresp", 64'(fifo_bresp), 64'd2);
        chk("t4_bid", 64'(fifo_bid), 64'd1);
        cycle();
        bvalid = 1'b0;
        chk("t4_one_push", 64'(bl.size()), 64'd1);
        chk("t4_push_data", 64'(bl[0]), 64'h6);
        chk("t4_out0", 64'(outstanding), 64'd0);

        // wlast mismatch
        clear_logs();
        push_aw(1'b0, 32'h5000, 8'd1);
        push_w(64'h61, 1'b1);
        push_w(64'h62, 1'b0);
        chk("t5_err_clear", 64'(wlast_err), 64'd0);
        wait_beats(1, 20, "t5_beat1_timeout");
        chk("t5_err_set", 64'(wlast_err), 64'd1);
        wait_beats(2, 20, "t5_beat2_timeout");
        cycles(3);
        chk("t5_beats", 64'(wl_data.size()), 64'd2);
        chk("t5_gen_wlast0", 64'(wl_last[0]), 64'd0);
        chk("t5_gen_wlast1", 64'(wl_last[1]), 64'd1);
        send_b(1'b0, 2'b00);
        cycles(2);
        chk("t5_err_sticky", 64'(wlast_err), 64'd1);
        chk("t5_out0", 64'(outstanding), 64'd0);

        // simultaneous AW handshake and B push
        clear_logs();
        push_aw(1'b0, 32'h6000, 8'd0); push_w(64'h71, 1'b1);
        push_aw(1'b0, 32'h6100, 8'd0); push_w(64'h72, 1'b1);
        cycles(10);
        chk("t6_out2", 64'(outstanding), 64'd2);
        awready = 1'b0;
        push_aw(1'b0, 32'h6200, 8'd0); push_w(64'h73, 1'b1);
        for (int k = 0; k < 10 && !awvalid; k++) cycle();
        chk("t6_awvalid", 64'(awvalid), 64'd1);
        awready = 1'b1; bvalid = 1'b1; bid = 1'b0; bresp = 2'b00;
        drive();
        chk("t6_bpush_same", 64'(b_wr_en), 64'd1);
        cycle();
        bvalid = 1'b0;
        chk("t6_out_net", 64'(outstanding), 64'd2);

        // reset mid-burst
        clear_logs();
        push_aw(1'b0, 32'h7000, 8'd3);
        push_w(64'h81, 1'b0); push_w(64'h82, 1'b0);
        wait_beats(1, 20, "t6_burst_timeout");
        chk("t6_out3", 64'(outstanding), 64'd3);
        aresetn = 1'b0;
        cycle();
        chk("t6_rst_awvalid", 64'(awvalid), 64'd0);
        chk("t6_rst_out", 64'(outstanding), 64'd0);
        chk("t6_rst_wvalid", 64'(wvalid), 64'd0);
        aresetn = 1'b1;
        awq.delete(); wq.delete();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
